// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states
// and the op classification helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } md_state_t;

    // Arithmetic ops occupy codes 0..3, so bit 2 clear identifies them.
    function automatic logic is_arith(md_op_t op);
        return !op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract
// for divide. acc holds {partial, multiplier} or {remainder, quotient}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd_i};
        if (is_div_i) begin
            // Borrow out of the trial subtract means the divisor did not fit.
            if (diff[WIDTH])
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            else
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO: signs are stripped at accept,
// WIDTH magnitude iterations run, and the FIX cycle re-applies signs.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic               div0_q, div0_d, done_q, done_d;
    logic               sgn, a_neg, b_neg;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (div_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        done_d  = 1'b0;

        sgn   = (op == MD_MULT) || (op == MD_DIV);
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        prod  = neg_q ? -acc_q : acc_q;
        quot  = acc_q[WIDTH-1:0];
        rem   = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (is_arith(op)) begin
                        state_d = ST_CALC;
                        cnt_d   = '0;
                        div_d   = op[1];
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        div0_d  = (b == '0);
                        acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        opnd_d  = op[1] ? b_mag : a_mag;
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        // Remainder takes the dividend's sign, so divide-by-zero
                        // hands back the original dividend in HI.
                        lo_d = div0_q ? '1 : (neg_q ? -quot : quot);
                        hi_d = rneg_q ? -rem : rem;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: hand-computed results, latency, handshake,
// flush and asynchronous reset behaviour.
module tb_alu_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, flush;
    md_op_t       op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the accepting edge E0.
    task automatic issue(input md_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // n = edges until done is seen; bc = post-edge samples with busy high.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) bc++;
        end
    endtask

    task automatic do_op(input string tag, input md_op_t o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n, bc;
        issue(o, x, y);
        wait_done(n, bc);
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_busy"}, 64'(bc), 64'd33);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bc, seen;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = MD_MULT; a = '0; b = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mult", MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        @(posedge clk); #1;
        chk("mult_done_pulse", 64'(done), 64'd0);

        // start mid-operation must neither disturb nor be queued
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (3) @(posedge clk);
        #4;
        op = MD_MTHI; a = 32'h0000DEAD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("multu_busy_mid", 64'(busy), 64'd1);
        wait_done(n, bc);
        chk("multu_lat", 64'(n), 64'd29);
        chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_lo", 64'(lo), 64'h00000001);
        @(posedge clk); #1;
        chk("multu_noqueue_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_noqueue_busy", 64'(busy), 64'd0);

        do_op("multu_2p16", MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
        do_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        do_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        do_op("divu_by0", MD_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        do_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        op = MD_MTHI; a = 32'h00001234; start = 1'b1;
        @(posedge clk); #1;
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        op = MD_MTLO; a = 32'h00005678;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h5678);
        chk("mtlo_hi", 64'(hi), 64'h1234);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);

        // flush beats start in IDLE
        @(negedge clk);
        op = MD_MULT; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_start_busy", 64'(busy), 64'd0);
        op = MD_MTHI; a = 32'h0000BEEF;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_mthi_hi", 64'(hi), 64'h1234);

        // unused op code
        @(negedge clk);
        op = md_op_t'(3'd6); a = 32'h0000AAAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("op6_busy", 64'(busy), 64'd0);
        chk("op6_hi", 64'(hi), 64'h1234);
        chk("op6_lo", 64'(lo), 64'h5678);

        // flush at iteration 10
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("flush_nodone", 64'(seen), 64'd0);
        chk("flush_hi", 64'(hi), 64'h1234);
        chk("flush_lo", 64'(lo), 64'h5678);

        // back-to-back: second start in the done cycle of the first
        issue(MD_MULT, 32'd6, 32'd7);
        wait_done(n, bc);
        chk("b2b1_lat", 64'(n), 64'd33);
        chk("b2b1_hi", 64'(hi), 64'd0);
        chk("b2b1_lo", 64'(lo), 64'd42);
        op = MD_DIV; a = 32'hFFFFFF9C; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b2_accept", 64'(busy), 64'd1);
        wait_done(n, bc);
        chk("b2b2_lat", 64'(n), 64'd33);
        chk("b2b2_hi", 64'(hi), 64'hFFFFFFFE);
        chk("b2b2_lo", 64'(lo), 64'hFFFFFFF2);

        // asynchronous reset mid-MULT
        issue(MD_MULT, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
